// File: rtl/decode_stage_if.sv
// Handshake bundles between fetch and decode, and decode and execute.
// Masters drive valid plus payload; slaves drive ready.
interface fetch_if #(
  parameter int XLEN = 64
);
  logic            valid;
  logic            ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;

  modport master (output valid, instr, pc, input ready);
  modport slave  (input valid, instr, pc, output ready);
endinterface

interface decode_if #(
  parameter int XLEN = 64
);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic [15:0]     ctrl;
  logic            illegal;

  modport master (
    output valid, pc, rs1, rs2, rd, imm, fmt, ctrl, illegal,
    input  ready
  );
  modport slave (
    input  valid, pc, rs1, rs2, rd, imm, fmt, ctrl, illegal,
    output ready
  );
endinterface

// File: rtl/decode_stage.sv
// RV64I instruction decode behind one valid/ready pipeline register.
// ctrl = {rw, mrd, mwr, msz[1:0], muns, uimm, br, jmp, word, alu[3:0], ecall, ebreak}.
module decode_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  fetch_if.slave          fetch,
  decode_if.master        decode,
  output logic [XLEN-1:0] id_count
);
  localparam logic [2:0] FR = 3'd0, FI = 3'd1, FS = 3'd2, FB = 3'd3;
  localparam logic [2:0] FU = 3'd4, FJ = 3'd5, FSYS = 3'd6;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2;
  localparam logic [3:0] A_SLT = 4'd3, A_SLTU = 4'd4, A_XOR = 4'd5;
  localparam logic [3:0] A_SRL = 4'd6, A_SRA = 4'd7, A_OR = 4'd8;
  localparam logic [3:0] A_AND = 4'd9;

  function automatic logic [3:0] alu_of(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] op;
    unique case (f3)
      3'd0: op = alt ? A_SUB : A_ADD;
      3'd1: op = A_SLL;
      3'd2: op = A_SLT;
      3'd3: op = A_SLTU;
      3'd4: op = A_XOR;
      3'd5: op = alt ? A_SRA : A_SRL;
      3'd6: op = A_OR;
      3'd7: op = A_AND;
    endcase
    return op;
  endfunction

  logic [31:0] ins;
  logic [2:0]  f3;
  logic [6:0]  f7;
  assign ins = fetch.instr;
  assign f3  = ins[14:12];
  assign f7  = ins[31:25];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{(XLEN-12){ins[31]}}, ins[31:20]};
  assign imm_s = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{(XLEN-13){ins[31]}}, ins[31], ins[7],
                  ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12],
                  ins[20], ins[30:21], 1'b0};

  logic            bad, rw, mr, mw, mu, ui, br, jp, wd, ec, eb;
  logic [1:0]      msz;
  logic [3:0]      alu;
  logic [2:0]      fmt;
  logic [XLEN-1:0] imm;
  logic [4:0]      rs1, rs2, rd;
  logic [15:0]     ctrl;
  logic [2:0]      fmt_o;
  logic [XLEN-1:0] imm_o;

  // Opcode decode: format, immediate, control flags and legality.
  always_comb begin
    bad = 1'b0;
    rw  = 1'b0;
    mr  = 1'b0;
    mw  = 1'b0;
    mu  = 1'b0;
    ui  = 1'b0;
    br  = 1'b0;
    jp  = 1'b0;
    wd  = 1'b0;
    ec  = 1'b0;
    eb  = 1'b0;
    msz = 2'b00;
    alu = A_ADD;
    fmt = FSYS;
    imm = '0;
    unique case (ins[6:0])
      7'h37, 7'h17: begin
        fmt = FU; imm = imm_u; rw = 1'b1; ui = 1'b1;
      end
      7'h6f: begin
        fmt = FJ; imm = imm_j; rw = 1'b1; ui = 1'b1; jp = 1'b1;
      end
      7'h67: begin
        fmt = FI; imm = imm_i; rw = 1'b1; ui = 1'b1; jp = 1'b1;
      end
      7'h63: begin
        fmt = FB; imm = imm_b; br = 1'b1;
        alu = f3[2] ? (f3[1] ? A_SLTU : A_SLT) : A_SUB;
        bad = (f3[2:1] == 2'b01);
      end
      7'h03: begin
        fmt = FI; imm = imm_i; rw = 1'b1; mr = 1'b1; ui = 1'b1;
        msz = f3[1:0]; mu = f3[2];
        bad = (f3 == 3'd7);
      end
      7'h23: begin
        fmt = FS; imm = imm_s; mw = 1'b1; ui = 1'b1;
        msz = f3[1:0];
        bad = f3[2];
      end
      7'h13: begin
        fmt = FI; imm = imm_i; rw = 1'b1; ui = 1'b1;
        alu = alu_of(f3, f3 == 3'd5 && ins[30]);
        if (f3 == 3'd1)
          bad = (ins[31:26] != 6'h00);
        else if (f3 == 3'd5)
          bad = (ins[31:26] != 6'h00) && (ins[31:26] != 6'h10);
      end
      7'h33: begin
        fmt = FR; rw = 1'b1;
        alu = alu_of(f3, ins[30]);
        bad = !((f7 == 7'h00) ||
                (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'h1b: begin
        fmt = FI; imm = imm_i; rw = 1'b1; ui = 1'b1; wd = 1'b1;
        alu = alu_of(f3, f3 == 3'd5 && ins[30]);
        if (f3 == 3'd1)
          bad = (f7 != 7'h00);
        else if (f3 == 3'd5)
          bad = (f7 != 7'h00) && (f7 != 7'h20);
        else
          bad = (f3 != 3'd0);
      end
      7'h3b: begin
        fmt = FR; rw = 1'b1; wd = 1'b1;
        alu = alu_of(f3, ins[30]);
        bad = !(((f3 == 3'd0 || f3 == 3'd5) &&
                 (f7 == 7'h00 || f7 == 7'h20)) ||
                (f3 == 3'd1 && f7 == 7'h00));
      end
      7'h0f: begin
        fmt = FI; imm = imm_i;
      end
      7'h73: begin
        ec  = (ins == 32'h0000_0073);
        eb  = (ins == 32'h0010_0073);
        bad = !(ec || eb);
      end
      default: bad = 1'b1;
    endcase
    if (ins[1:0] != 2'b11)
      bad = 1'b1;
  end

  // Operand fields gated by format; illegal words squash the whole bundle.
  always_comb begin
    rs1   = '0;
    rs2   = '0;
    rd    = '0;
    ctrl  = '0;
    fmt_o = FSYS;
    imm_o = '0;
    if (!bad) begin
      fmt_o = fmt;
      imm_o = imm;
      if (fmt == FR || fmt == FI || fmt == FS || fmt == FB)
        rs1 = ins[19:15];
      if (fmt == FR || fmt == FS || fmt == FB)
        rs2 = ins[24:20];
      if (fmt == FR || fmt == FI || fmt == FU || fmt == FJ)
        rd = ins[11:7];
      ctrl = {rw && (rd != 5'd0), mr, mw, msz, mu, ui,
              br, jp, wd, alu, ec, eb};
    end
  end

  logic            v_q, ill_q;
  logic [XLEN-1:0] pc_q, imm_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [2:0]      fmt_q;
  logic [15:0]     ctrl_q;
  logic            accept, handoff;

  assign fetch.ready = (!v_q || decode.ready) && !flush;
  assign accept      = fetch.valid && fetch.ready;
  assign handoff     = v_q && decode.ready;

  // Occupancy and handoff counter; flush wins over everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q      <= 1'b0;
      id_count <= '0;
    end else begin
      if (flush)
        v_q <= 1'b0;
      else if (accept)
        v_q <= 1'b1;
      else if (handoff)
        v_q <= 1'b0;
      if (handoff && !flush)
        id_count <= id_count + XLEN'(1);
    end
  end

  // Bundle register loads only on accept, so it holds during stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= '0;
      imm_q  <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      fmt_q  <= '0;
      ctrl_q <= '0;
      ill_q  <= 1'b0;
    end else if (accept) begin
      pc_q   <= fetch.pc;
      imm_q  <= imm_o;
      rs1_q  <= rs1;
      rs2_q  <= rs2;
      rd_q   <= rd;
      fmt_q  <= fmt_o;
      ctrl_q <= ctrl;
      ill_q  <= bad;
    end
  end

  assign decode.valid   = v_q;
  assign decode.pc      = pc_q;
  assign decode.imm     = imm_q;
  assign decode.rs1     = rs1_q;
  assign decode.rs2     = rs2_q;
  assign decode.rd      = rd_q;
  assign decode.fmt     = fmt_q;
  assign decode.ctrl    = ctrl_q;
  assign decode.illegal = ill_q;
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 64, datapath/PC/immediate width; only 64 is supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 if_valid  input  1  fetch presents an instruction this cycle.
REQ-005 if_ready  output  1  decode accepts the instruction this cycle.
REQ-006 if_instr  input  32  raw RV64I instruction word.
REQ-007 if_pc  input  XLEN  address of if_instr.
REQ-008 flush  input  1  discard held and incoming instructions (redirect).
REQ-009 id_valid  output  1  decoded bundle valid toward execute.
REQ-010 id_ready  input  1  execute accepts bundle this cycle.
REQ-011 id_pc  output  XLEN  PC of held instruction.
REQ-012 id_rs1, id_rs2, id_rd  output  5 each  register indices; forced to 0 when the format does not use the field.
REQ-013 id_imm  output  XLEN  sign-extended immediate (I/S/B/U/J); 0 for R-type.
REQ-014 id_fmt  output  3  format: 0=R,1=I,2=S,3=B,4=U,5=J,6=SYS.
REQ-015 id_ctrl  output  16  {reg_write, mem_read, mem_write, mem_size[1:0], mem_unsigned, use_imm, branch, jump, is_word, alu_op[3:0], ecall, ebreak}.
REQ-016 id_illegal  output  1  held instruction is not legal RV64I.
REQ-017 id_count  output  XLEN  number of bundles handed to execute since reset.

Function
REQ-018 Single pipeline register; latency exactly 1 cycle from accept (if_valid && if_ready) to id_valid.
REQ-019 if_ready SHALL equal (!id_valid || id_ready) && !flush, combinationally.
REQ-020 On accept, all id_* bundle outputs load decoded fields of if_instr/if_pc and id_valid goes 1 next cycle.
REQ-021 While id_valid && !id_ready, all id_* bundle outputs hold stable.
REQ-022 Handoff (id_valid && id_ready) without simultaneous accept clears id_valid next cycle; with accept, id_valid stays 1 and new bundle loads (back-to-back, no bubble).
REQ-023 flush clears id_valid next cycle regardless of id_ready or if_valid; incoming instruction in the flush cycle is dropped; id_count not incremented for a handoff coincident with flush.
REQ-024 id_count increments by 1 on each handoff; wraps 2^64-1 -> 0.
REQ-025 Decoded opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, OP-IMM-32, OP-32, MISC-MEM (FENCE as no-op I-type), SYSTEM (ECALL 0x00000073, EBREAK 0x00100073 only).
REQ-026 id_illegal=1 when: instr[1:0]!=2'b11; unknown opcode; invalid funct3/funct7 combination for OP/OP-32/shift-immediate; LOAD funct3=3'b111; STORE funct3>3'b011; BRANCH funct3 2 or 3; any other SYSTEM encoding; instr==0.
REQ-027 Illegal bundle: id_ctrl all 0, id_imm 0, id_fmt 6; it still flows and counts as a handoff.
REQ-028 RV64 shift immediates use 6-bit shamt (instr[25:20]); *-32 variants require instr[25]=0 else illegal.
REQ-029 U-type id_imm = sign-extend({instr[31:12],12'b0}) to 64 bits.
REQ-030 rd=x0 clears reg_write.

Reset
REQ-031 reset asynchronously forces id_valid=0, id_count=0, id_pc=0, id_imm=0, id_rs1/rs2/rd=0, id_fmt=0, id_ctrl=0, id_illegal=0.
REQ-032 Reset asserted mid-operation discards the held bundle; first accept occurs the first clk edge after reset deasserts with if_valid=1.

Verification
REQ-033 Accept 0x00500093 (addi x1,x0,5) pc 0x80000000 -> next cycle id_valid=1, rd=1, rs1=0, imm=5, fmt=1, reg_write=1, use_imm=1.
REQ-034 0x00112423 (sw x1,8(x2)) -> rs1=2, rs2=1, rd=0, imm=8, fmt=2, mem_write=1, mem_size=2'b10, reg_write=0.
REQ-035 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFFFFFFFFFC, fmt=3, branch=1; 0x800002B7 (lui) -> imm=0xFFFFFFFF80000000.
REQ-036 id_ready=0 for 5 cycles with if_valid=1 -> bundle stable, if_ready=0, id_count unchanged; id_ready=1 -> id_count=1, next instruction loads same edge.
REQ-037 flush asserted with id_valid=1, id_ready=1, if_valid=1 -> id_valid=0 next cycle, id_count unchanged, incoming dropped.
REQ-038 0x00000000 and 0x02001013 (slli with funct7 bit 25 set is legal 6-bit shamt) vs 0x0200101B (slliw shamt[5]=1) -> illegal=1, 0, 1 respectively.
